uart_tx_feeder: RTL and testbench

Wishbone master that buffers outbound bytes and writes them one at a time into the `uart1` transmit register. It sits directly upstream of `uart1` in `soc1`. It replaces the timer-driven single-byte strobe with a FIFO-backed producer, so any logic or the future CPU glue can push bytes at clock rate without tracking UART busy state. Each byte becomes one Wishbone write cycle to `ADR`, held until `ack_i`.

---
 rtl/uart_tx_feeder.sv | 148 ++++++++++++++
 tb/tb_uart_tx_feeder.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: FIFO-backed Wishbone master that writes queued bytes,
// one per bus cycle, into the uart1 TX register at address ADR.
// Ports: clk_48_i, rst_i (sync, active-high); push side byte_i/valid_i/
// ready_o/level_o; busy_o status; Wishbone adr_o/dat_o/we_o/sel_o/stb_o/
// cyc_o/ack_i; drop_o pulses when a write is abandoned on timeout.
// Define UART_TX_FEEDER_TIMEOUT_EN to abandon writes not acked in TIMEOUT.
module uart_tx_feeder #(
  parameter logic [31:0] ADR     = 32'h0FF,
  parameter int          DEPTH   = 16,
  parameter int          TIMEOUT = 1024
) (
  input  logic                   clk_48_i,
  input  logic                   rst_i,
  input  logic [7:0]             byte_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   busy_o,
  output logic [31:0]            adr_o,
  output logic [31:0]            dat_o,
  output logic                   we_o,
  output logic [3:0]             sel_o,
  output logic                   stb_o,
  output logic                   cyc_o,
  input  logic                   ack_i,
  output logic                   drop_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1)
  begin : g_bad_cfg
    $error("uart_tx_feeder: DEPTH/TIMEOUT out of range");
  end

  typedef enum logic {IDLE, REQ} state_t;

  state_t        state, state_d;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          push, pop, expire;
  logic [31:0]   adr_d, dat_d;
  logic [3:0]    sel_d;
  logic          we_d, stb_d, cyc_d, drop_d;

  assign ready_o = (count != CW'(DEPTH));
  assign level_o = count;
  assign busy_o  = (count != '0) || (state == REQ);
  assign push    = valid_i && ready_o;
  // The head entry stays in the FIFO until its bus cycle ends.
  assign pop     = (state == REQ) && (ack_i || expire);

  always_ff @(posedge clk_48_i) begin
    if (push) mem[wptr] <= byte_i;
  end

  always_ff @(posedge clk_48_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef UART_TX_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;

  always_ff @(posedge clk_48_i) begin
    if (rst_i || state == IDLE) tcnt <= '0;
    else if (!ack_i)            tcnt <= tcnt + TW'(1);
  end

  // A late ack on the expiry cycle still wins.
  assign expire = (state == REQ) && !ack_i &&
                  (tcnt == TW'(TIMEOUT - 1));
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk_48_i) begin
    if (rst_i) begin
      state  <= IDLE;
      adr_o  <= '0;
      dat_o  <= '0;
      sel_o  <= '0;
      we_o   <= 1'b0;
      stb_o  <= 1'b0;
      cyc_o  <= 1'b0;
      drop_o <= 1'b0;
    end else begin
      state  <= state_d;
      adr_o  <= adr_d;
      dat_o  <= dat_d;
      sel_o  <= sel_d;
      we_o   <= we_d;
      stb_o  <= stb_d;
      cyc_o  <= cyc_d;
      drop_o <= drop_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (count != '0) state_d = REQ;
      REQ:     if (pop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    adr_d  = adr_o;
    dat_d  = dat_o;
    sel_d  = sel_o;
    we_d   = we_o;
    stb_d  = stb_o;
    cyc_d  = cyc_o;
    drop_d = 1'b0;
    unique case (1'b1)
      (state == IDLE) && (count != '0): begin
        adr_d = ADR;
        dat_d = {24'b0, mem[rptr]};
        sel_d = 4'b0001;
        we_d  = 1'b1;
        stb_d = 1'b1;
        cyc_d = 1'b1;
      end
      pop: begin
        we_d   = 1'b0;
        stb_d  = 1'b0;
        cyc_d  = 1'b0;
        drop_d = expire;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: scoreboard bench for uart_tx_feeder with a
// configurable-delay Wishbone slave and a FIFO occupancy model.
`timescale 1ns/1ps
module tb_uart_tx_feeder;
  localparam int DEPTH = 16;
  localparam int TMO   = 8;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  byte_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [4:0]  level_o;
  logic        busy_o;
  logic [31:0] adr_o, dat_o;
  logic        we_o;
  logic [3:0]  sel_o;
  logic        stb_o, cyc_o;
  logic        ack_i = 1'b0;
  logic        drop_o;

  always #5 clk = ~clk;

  uart_tx_feeder #(
    .ADR(32'h0FF), .DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .clk_48_i(clk), .rst_i(rst_i),
    .byte_i(byte_i), .valid_i(valid_i),
    .ready_o(ready_o), .level_o(level_o),
    .busy_o(busy_o), .adr_o(adr_o),
    .dat_o(dat_o), .we_o(we_o),
    .sel_o(sel_o), .stb_o(stb_o),
    .cyc_o(cyc_o), .ack_i(ack_i),
    .drop_o(drop_o)
  );

  typedef struct packed {
    logic [31:0] dat;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
  } wr_t;

  wr_t        got_q[$];
  logic [7:0] exp_q[$];
  wr_t        cap;
  int         n_chk = 0;
  int         n_fail = 0;
  int         mdl_lvl = 0;
  int         pend = 0;
  int         wcnt = 0;
  int         ack_delay = 0;
  logic       ack_en = 1'b0;

  // Wishbone slave plus occupancy model, updated just after each edge.
  always @(posedge clk) begin
    #1;
    if (rst_i) begin
      ack_i = 1'b0;
      wcnt = 0;
      mdl_lvl = 0;
      pend = 0;
    end else begin
      mdl_lvl = mdl_lvl + pend - ((ack_i || drop_o) ? 1 : 0);
      pend = 0;
      if (ack_i) begin
        got_q.push_back(cap);
        ack_i = 1'b0;
        wcnt = 0;
      end else if (ack_en && stb_o) begin
        if (wcnt >= ack_delay) begin
          ack_i = 1'b1;
          cap = '{dat: dat_o, adr: adr_o, sel: sel_o, we: we_o};
        end else begin
          wcnt++;
        end
      end
    end
  end

  task automatic step(input logic v, input logic [7:0] b,
                      output logic acc);
    @(negedge clk);
    valid_i = v;
    byte_i = b;
    acc = v && (mdl_lvl < DEPTH);
    pend = acc ? 1 : 0;
    if (acc) exp_q.push_back(b);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({cyc_o, stb_o, we_o, drop_o} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 0000",
               {cyc_o, stb_o, we_o, drop_o});
    end
    n_chk++;
    if (adr_o !== 32'h0 || dat_o !== 32'h0 || sel_o !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_bus: adr %h dat %h sel %h want 0",
               adr_o, dat_o, sel_o);
    end
    n_chk++;
    if (level_o !== 5'd0 || ready_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stat: lvl %0d rdy %b busy %b want 0 1 0",
               level_o, ready_o, busy_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_single();
    logic acc;
    wr_t w;
    logic [7:0] e;
    exp_q.delete();
    got_q.delete();
    ack_en = 1'b1;
    ack_delay = 2;
    step(1'b1, 8'h54, acc);
    step(1'b0, 8'h00, acc);
    n_chk++;
    if (level_o !== 5'd1 || stb_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pre: lvl %0d stb %b want 1 0",
               level_o, stb_o);
    end
    @(negedge clk);
    n_chk++;
    if ({stb_o, cyc_o, we_o} !== 3'b111 || dat_o !== 32'h54 ||
        adr_o !== 32'h0FF || sel_o !== 4'h1) begin
      n_fail++;
      $display("FAIL single_req: ctl %b dat %h adr %h sel %h",
               {stb_o, cyc_o, we_o}, dat_o, adr_o, sel_o);
    end
    for (int t = 0; t < 20 && got_q.size() == 0; t++)
      @(negedge clk);
    n_chk++;
    if (got_q.size() !== 1) begin
      n_fail++;
      $display("FAIL single_ack: writes %0d want 1", got_q.size());
    end
    n_chk++;
    if (stb_o !== 1'b0 || level_o !== 5'd0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_end: stb %b lvl %0d busy %b want 0 0 0",
               stb_o, level_o, busy_o);
    end
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      w = got_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (w.dat !== {24'b0, e}) begin
        n_fail++;
        $display("FAIL single_data: got %h want %h", w.dat, e);
      end
    end
  endtask

  task automatic test_fill();
    logic acc;
    int k;
    wr_t w;
    logic [7:0] e;
    exp_q.delete();
    got_q.delete();
    ack_en = 1'b0;
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), acc);
    step(1'b1, 8'hAA, acc);
    step(1'b0, 8'h00, acc);
    n_chk++;
    if (ready_o !== 1'b0 || level_o !== 5'd16) begin
      n_fail++;
      $display("FAIL fill_full: rdy %b lvl %0d want 0 16",
               ready_o, level_o);
    end
    ack_delay = 0;
    ack_en = 1'b1;
    acc = 1'b0;
    k = 0;
    while (!acc && k < 10) begin
      step(1'b1, 8'hBB, acc);
      k++;
    end
    n_chk++;
    if (level_o !== 5'd15 || ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pop: lvl %0d rdy %b want 15 1",
               level_o, ready_o);
    end
    step(1'b0, 8'h00, acc);
    n_chk++;
    if (level_o !== 5'd16) begin
      n_fail++;
      $display("FAIL refill: lvl %0d want 16", level_o);
    end
    for (int t = 0; t < 200 && got_q.size() < 17; t++)
      @(negedge clk);
    n_chk++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL fill_count: got %0d want %0d",
               got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      w = got_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (w.dat !== {24'b0, e} || w.adr !== 32'h0FF ||
          w.sel !== 4'h1 || w.we !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_data: got %h want %h", w.dat, e);
      end
    end
    n_chk++;
    if (level_o !== 5'd0) begin
      n_fail++;
      $display("FAIL fill_empty: lvl %0d want 0", level_o);
    end
  endtask

  task automatic test_wrap();
    logic acc;
    wr_t w;
    logic [7:0] e;
    exp_q.delete();
    got_q.delete();
    ack_en = 1'b1;
    ack_delay = 1;
    for (int i = 0; i < 40; i++) begin
      acc = 1'b0;
      for (int t = 0; t < 50 && !acc; t++) begin
        step(1'b1, 8'(i * 37 + 5), acc);
        n_chk++;
        if (level_o !== 5'(mdl_lvl) ||
            ready_o !== (mdl_lvl < DEPTH)) begin
          n_fail++;
          $display("FAIL wrap_level: lvl %0d rdy %b want %0d",
                   level_o, ready_o, mdl_lvl);
        end
      end
    end
    step(1'b0, 8'h00, acc);
    for (int t = 0; t < 400 && got_q.size() < 40; t++)
      @(negedge clk);
    n_chk++;
    if (got_q.size() !== 40) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d want 40", got_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      w = got_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (w.dat !== {24'b0, e}) begin
        n_fail++;
        $display("FAIL wrap_data: got %h want %h", w.dat, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic acc;
    int bad;
    exp_q.delete();
    got_q.delete();
    ack_en = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), acc);
    step(1'b0, 8'h00, acc);
    n_chk++;
    if (stb_o !== 1'b1 || level_o !== 5'd5) begin
      n_fail++;
      $display("FAIL mid_req: stb %b lvl %0d want 1 5",
               stb_o, level_o);
    end
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    n_chk++;
    if ({cyc_o, stb_o, drop_o} !== 3'b000 || level_o !== 5'd0 ||
        ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_rst: ctl %b lvl %0d rdy %b want 000 0 1",
               {cyc_o, stb_o, drop_o}, level_o, ready_o);
    end
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (drop_o !== 1'b0 || stb_o !== 1'b0) bad++;
    end
    n_chk++;
    if (bad !== 0 || got_q.size() !== 0) begin
      n_fail++;
      $display("FAIL mid_after: bad %0d writes %0d want 0 0",
               bad, got_q.size());
    end
    exp_q.delete();
  endtask

`ifdef UART_TX_FEEDER_TIMEOUT_EN
  task automatic test_timeout();
    logic acc;
    int k;
    wr_t w;
    exp_q.delete();
    got_q.delete();
    ack_en = 1'b0;
    step(1'b1, 8'h11, acc);
    step(1'b1, 8'h22, acc);
    step(1'b0, 8'h00, acc);
    k = 0;
    while (drop_o !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (k !== TMO || stb_o !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_drop: delay %0d stb %b want %0d 0",
               k, stb_o, TMO);
    end
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(negedge clk);
    n_chk++;
    if (stb_o !== 1'b1 || dat_o !== 32'h22 || drop_o !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_next: stb %b dat %h drop %b want 1 22 0",
               stb_o, dat_o, drop_o);
    end
    ack_delay = 0;
    ack_en = 1'b1;
    for (int t = 0; t < 20 && got_q.size() == 0; t++)
      @(negedge clk);
    n_chk++;
    if (got_q.size() !== 1) begin
      n_fail++;
      $display("FAIL tmo_count: got %0d want 1", got_q.size());
    end
    if (got_q.size() > 0) begin
      w = got_q.pop_front();
      n_chk++;
      if (w.dat !== 32'h22) begin
        n_fail++;
        $display("FAIL tmo_data: got %h want 22", w.dat);
      end
    end
  endtask
`else
  task automatic test_no_timeout();
    logic acc;
    int bad;
    wr_t w;
    exp_q.delete();
    got_q.delete();
    ack_en = 1'b0;
    step(1'b1, 8'h5A, acc);
    step(1'b0, 8'h00, acc);
    @(negedge clk);
    bad = 0;
    repeat (10000) begin
      @(negedge clk);
      if (stb_o !== 1'b1 || drop_o !== 1'b0) bad++;
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL hold: %0d bad cycles want 0", bad);
    end
    ack_delay = 0;
    ack_en = 1'b1;
    for (int t = 0; t < 20 && got_q.size() == 0; t++)
      @(negedge clk);
    n_chk++;
    if (got_q.size() !== 1) begin
      n_fail++;
      $display("FAIL hold_count: got %0d want 1", got_q.size());
    end
    if (got_q.size() > 0) begin
      w = got_q.pop_front();
      n_chk++;
      if (w.dat !== 32'h5A) begin
        n_fail++;
        $display("FAIL hold_data: got %h want 5a", w.dat);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_reset_mid();
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
